// File: rtl/i3c_line_pkg.sv
// Shared constants for the I3C line conditioner: parameter defaults, legal
// maxima and the counter widths derived from them.
package i3c_line_pkg;

    localparam int FILT_CYC_DEF = 3;
    localparam int FILT_CYC_MAX = 15;
    localparam int IDLE_CYC_DEF = 200;
    localparam int IDLE_CYC_MAX = 65535;

    localparam int FILT_CNT_W = $clog2(FILT_CYC_MAX + 1);
    localparam int IDLE_CNT_W = $clog2(IDLE_CYC_MAX + 1);

endpackage

// File: rtl/i3c_glitch_filter.sv
// One bus line: 2-flop synchronizer followed by a stable-count glitch filter.
// Raw edge to filtered edge is exactly 2+FILT_CYC cycles.
module i3c_glitch_filter
    import i3c_line_pkg::*;
#(
    parameter int FILT_CYC = FILT_CYC_DEF
) (
    input  logic pclk,
    input  logic areset,
    input  logic line,
    output logic filt
);

    localparam logic [FILT_CNT_W-1:0] LAST = FILT_CNT_W'(FILT_CYC - 1);

    logic                  sync1;
    logic                  sync2;
    logic [FILT_CNT_W-1:0] cnt;

    // The counter restarts on any cycle where the synchronized value agrees.
    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            filt  <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= line;
            sync2 <= sync1;
            if (sync2 != filt) begin
                if (cnt == LAST) begin
                    filt <= sync2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/i3c_line_conditioner.sv
// Per-channel SCL/SDA conditioning: filtering, START/Sr/STOP detection, bus
// busy/idle tracking and arbitration-loss detection. Optional idle timer is
// enabled with the macro I3C_LINE_IDLE_TIMER_EN.
module i3c_line_conditioner
    import i3c_line_pkg::*;
#(
    parameter int NUM_CH   = 1,
    parameter int FILT_CYC = FILT_CYC_DEF,
    parameter int IDLE_CYC = IDLE_CYC_DEF
) (
    input  logic              pclk,
    input  logic              areset,
    input  logic [NUM_CH-1:0] scl_i,
    input  logic [NUM_CH-1:0] sda_i,
    input  logic [NUM_CH-1:0] scl_pull_i,
    input  logic [NUM_CH-1:0] sda_pull_i,
    output logic [NUM_CH-1:0] scl_oen_o,
    output logic [NUM_CH-1:0] sda_oen_o,
    output logic [NUM_CH-1:0] scl_f_o,
    output logic [NUM_CH-1:0] sda_f_o,
    output logic [NUM_CH-1:0] start_o,
    output logic [NUM_CH-1:0] rstart_o,
    output logic [NUM_CH-1:0] stop_o,
    output logic [NUM_CH-1:0] arb_lost_o,
    output logic [NUM_CH-1:0] bus_busy_o,
    output logic [NUM_CH-1:0] bus_idle_o
);

    if (FILT_CYC < 1 || FILT_CYC > FILT_CYC_MAX || IDLE_CYC < 2 || IDLE_CYC > IDLE_CYC_MAX) begin : g_bad_param
        $error("i3c_line_conditioner: FILT_CYC or IDLE_CYC out of range");
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic scl_f, sda_f, scl_q, sda_q;
        logic start_c, stop_c, arb_c;
        logic scl_oen, sda_oen, start_r, rstart_r, stop_r, arb_r, busy, idle;

        i3c_glitch_filter #(.FILT_CYC(FILT_CYC)) u_scl (
            .pclk(pclk), .areset(areset), .line(scl_i[ch]), .filt(scl_f)
        );
        i3c_glitch_filter #(.FILT_CYC(FILT_CYC)) u_sda (
            .pclk(pclk), .areset(areset), .line(sda_i[ch]), .filt(sda_f)
        );

        // SCL must be high on both sides of the SDA edge, which also rejects
        // simultaneous SCL/SDA changes.
        always_comb begin
            start_c = scl_f & scl_q & sda_q & ~sda_f;
            stop_c  = scl_f & scl_q & ~sda_q & sda_f;
            arb_c   = scl_f & ~scl_q & busy & ~sda_oen & ~sda_f;
        end

`ifdef I3C_LINE_IDLE_TIMER_EN
        localparam logic [IDLE_CNT_W-1:0] IDLE_LIM = IDLE_CNT_W'(IDLE_CYC);
        logic [IDLE_CNT_W-1:0] idle_cnt;
        logic                  idle_hit;

        assign idle_hit = (idle_cnt == IDLE_LIM);

        // Saturating count of cycles with both filtered lines high.
        always_ff @(posedge pclk or posedge areset) begin
            if (areset) begin
                idle_cnt <= IDLE_CNT_W'(1);
            end else if (scl_f & sda_f) begin
                if (!idle_hit) idle_cnt <= idle_cnt + 1'b1;
            end else begin
                idle_cnt <= '0;
            end
        end
`endif

        always_ff @(posedge pclk or posedge areset) begin
            if (areset) begin
                scl_q    <= 1'b1;
                sda_q    <= 1'b1;
                scl_oen  <= 1'b0;
                sda_oen  <= 1'b0;
                start_r  <= 1'b0;
                rstart_r <= 1'b0;
                stop_r   <= 1'b0;
                arb_r    <= 1'b0;
                busy     <= 1'b0;
                idle     <= 1'b1;
            end else begin
                scl_q    <= scl_f;
                sda_q    <= sda_f;
                scl_oen  <= scl_pull_i[ch];
                sda_oen  <= sda_pull_i[ch];
                start_r  <= start_c & ~busy;
                rstart_r <= start_c & busy;
                stop_r   <= stop_c;
                arb_r    <= arb_c;
`ifdef I3C_LINE_IDLE_TIMER_EN
                // A long idle while busy recovers from a missed STOP silently.
                if (start_c)                busy <= 1'b1;
                else if (stop_c || idle_hit) busy <= 1'b0;
                idle <= idle_hit & ~busy;
`else
                if (start_c)     busy <= 1'b1;
                else if (stop_c) busy <= 1'b0;
                idle <= ~busy;
`endif
            end
        end

        assign scl_oen_o[ch]  = scl_oen;
        assign sda_oen_o[ch]  = sda_oen;
        assign scl_f_o[ch]    = scl_f;
        assign sda_f_o[ch]    = sda_f;
        assign start_o[ch]    = start_r;
        assign rstart_o[ch]   = rstart_r;
        assign stop_o[ch]     = stop_r;
        assign arb_lost_o[ch] = arb_r;
        assign bus_busy_o[ch] = busy;
        assign bus_idle_o[ch] = idle;
    end

endmodule

// File: doc/i3c_line_conditioner.md
I3C_LINE_CONDITIONER -- requirements
Module: i3c_line_conditioner

Interface
REQ-001 SHALL have parameter NUM_CH, default 1: number of independent SCL/SDA bus channels.
REQ-002 SHALL have parameter FILT_CYC, default 3: stable-cycle count for the glitch filter; legal range 1..15.
REQ-003 SHALL have parameter IDLE_CYC, default 200: bus-idle qualification time in pclk cycles; legal range 2..65535.
REQ-004 SHALL have port pclk, input, 1: the single clock.
REQ-005 SHALL have port areset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port scl_i, input, NUM_CH: raw sampled SCL per channel.
REQ-007 SHALL have port sda_i, input, NUM_CH: raw sampled SDA per channel.
REQ-008 SHALL have port scl_pull_i, input, NUM_CH: request to pull SCL low.
REQ-009 SHALL have port sda_pull_i, input, NUM_CH: request to pull SDA low.
REQ-010 SHALL have port scl_oen_o, output, NUM_CH: SCL driver enable, 1 = drive low.
REQ-011 SHALL have port sda_oen_o, output, NUM_CH: SDA driver enable, 1 = drive low.
REQ-012 SHALL have port scl_f_o, output, NUM_CH: filtered SCL.
REQ-013 SHALL have port sda_f_o, output, NUM_CH: filtered SDA.
REQ-014 SHALL have ports start_o, rstart_o, stop_o, arb_lost_o, output, NUM_CH each: single-cycle event pulses.
REQ-015 SHALL have ports bus_busy_o and bus_idle_o, output, NUM_CH each: bus status.

Function
REQ-016 Each raw line SHALL pass through a 2-flop synchronizer, then a glitch filter.
REQ-017 The filtered value SHALL change only after the synchronized value has differed from it for FILT_CYC consecutive cycles; the counter SHALL clear on any cycle of agreement.
REQ-018 Latency from a raw edge to the filtered output SHALL be exactly 2+FILT_CYC cycles.
REQ-019 START SHALL be a filtered SDA fall while filtered SCL is 1 in both the current and previous cycle.
REQ-020 A START with bus_busy_o=0 SHALL pulse start_o; a START with bus_busy_o=1 SHALL pulse rstart_o. Exactly one of the two fires.
REQ-021 STOP SHALL be a filtered SDA rise while filtered SCL is 1 in both the current and previous cycle; it pulses stop_o.
REQ-022 If filtered SCL and SDA change in the same cycle, no START or STOP SHALL be reported.
REQ-023 bus_busy_o SHALL set the cycle after START and clear the cycle after STOP.
REQ-024 scl_oen_o and sda_oen_o SHALL be the pull requests registered by one cycle.
REQ-025 On a filtered SCL rising edge with bus_busy_o=1, sda_oen_o=0 and filtered SDA=0, arb_lost_o SHALL pulse.
REQ-026 Channels SHALL be fully independent; no state is shared between them.

Reset
REQ-027 While areset=1: synchronizer flops, filtered lines and idle counters SHALL be 1.
REQ-028 While areset=1: filter counters SHALL be 0.
REQ-029 While areset=1: oen outputs, event pulses and bus_busy_o SHALL be 0, and bus_idle_o SHALL be 1.
REQ-030 Reset asserted mid-transfer SHALL abort immediately, with no STOP reported.
REQ-031 After reset deasserts, no event SHALL pulse until the lines genuinely transition.

Configuration
REQ-032 Macro I3C_LINE_IDLE_TIMER_EN defined: a per-channel counter SHALL count cycles with both filtered lines high and clear on any low.
REQ-033 With the macro, bus_idle_o SHALL assert once the count reaches IDLE_CYC and bus_busy_o=0.
REQ-034 With the macro, reaching IDLE_CYC while bus_busy_o=1 SHALL force bus_busy_o to 0 (lost-STOP recovery); this is not reported as stop_o.
REQ-035 Macro undefined: there SHALL be no counter, and bus_idle_o SHALL be the registered inverse of bus_busy_o.

Structure
REQ-036 Package i3c_line_pkg SHALL hold the FILT_CYC and IDLE_CYC default constants and the max-range constants.
REQ-037 Sub-module i3c_glitch_filter (synchronizer plus filter, one line) SHALL be instantiated 2*NUM_CH times.

Verification
REQ-038 FILT_CYC=3, SDA low pulse of 2 cycles -> sda_f_o unchanged, no events.
REQ-039 SCL=1, SDA 1->0 -> start_o pulses once, 5+1 cycles later, and bus_busy_o=1 the next cycle.
REQ-040 While busy, SDA 1->0 with SCL=1 -> rstart_o pulses, start_o stays 0; then SDA 0->1 with SCL=1 -> stop_o pulses and bus_busy_o=0.
REQ-041 NUM_CH=2, START on channel 1 only -> channel 0 outputs unchanged.
REQ-042 Busy, sda_pull_i=0, external SDA held 0, SCL 0->1 -> arb_lost_o pulses once.
REQ-043 With the macro, IDLE_CYC=20, START then lines held high 20 cycles -> bus_busy_o=0 and bus_idle_o=1 with no stop_o; without the macro -> bus_busy_o stays 1.
